// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit between execute and dbusif
// One op in flight: alignment check, single bus request, lane extraction, write-back or exception.
module lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ex_vld,
  input  logic        ex_we,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        lsu_busy,
  output logic        wb_vld,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        exc_vld,
  output logic [3:0]  exc_cause,
  output logic [31:0] exc_tval,
  output logic        acc_req,
  output logic        acc_w_rb,
  output logic [1:0]  acc_size,
  output logic [31:0] acc_addr,
  output logic [31:0] acc_wdata,
  input  logic        data_vld,
  input  logic [31:0] data,
  input  logic        data_has_fault
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

  state_t      state;
  logic        op_unsigned;
  logic [4:0]  op_rd;
  logic [31:0] cnt;

  logic        misaligned;
  logic [31:0] rep_wdata;
  logic [31:0] lane;
  logic [31:0] ld_val;
  logic [31:0] cnt_next;
  logic        timed_out;

  always_comb begin
    misaligned = 1'b0;
    rep_wdata  = ex_wdata;
    ld_val     = 32'd0;
    case (ex_size)
      2'd1:    misaligned = ex_addr[0];
      2'd2:    misaligned = |ex_addr[1:0];
      2'd3:    misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
    case (ex_size)
      2'd0:    rep_wdata = {4{ex_wdata[7:0]}};
      2'd1:    rep_wdata = {2{ex_wdata[15:0]}};
      default: rep_wdata = ex_wdata;
    endcase
    // acc_addr/acc_size double as the latched op address and size
    lane = data >> {acc_addr[1:0], 3'b000};
    case (acc_size)
      2'd0:    ld_val = {{24{lane[7] & ~op_unsigned}}, lane[7:0]};
      2'd1:    ld_val = {{16{lane[15] & ~op_unsigned}}, lane[15:0]};
      default: ld_val = lane;
    endcase
    cnt_next  = (&cnt) ? cnt : cnt + 32'd1;
    timed_out = (TIMEOUT != 0) && (cnt_next >= TIMEOUT);
  end

  assign lsu_busy = ((state == IDLE) && ex_vld) || (state == WAIT);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      op_unsigned <= 1'b0;
      op_rd       <= 5'd0;
      cnt         <= 32'd0;
      wb_vld      <= 1'b0;
      wb_we       <= 1'b0;
      wb_rd       <= 5'd0;
      wb_data     <= 32'd0;
      exc_vld     <= 1'b0;
      exc_cause   <= 4'd0;
      exc_tval    <= 32'd0;
      acc_req     <= 1'b0;
      acc_w_rb    <= 1'b0;
      acc_size    <= 2'd0;
      acc_addr    <= 32'd0;
      acc_wdata   <= 32'd0;
    end else begin
      acc_req   <= 1'b0;
      wb_vld    <= 1'b0;
      wb_we     <= 1'b0;
      wb_rd     <= 5'd0;
      wb_data   <= 32'd0;
      exc_vld   <= 1'b0;
      exc_cause <= 4'd0;
      exc_tval  <= 32'd0;
      case (state)
        IDLE: begin
          if (ex_vld) begin
            op_unsigned <= ex_unsigned;
            op_rd       <= ex_rd;
            acc_w_rb    <= ex_we;
            acc_size    <= ex_size;
            acc_addr    <= ex_addr;
            acc_wdata   <= rep_wdata;
            if (misaligned) begin
              state     <= DONE;
              exc_vld   <= 1'b1;
              exc_cause <= ex_we ? 4'd6 : 4'd4;
              exc_tval  <= ex_addr;
            end else begin
              state   <= WAIT;
              acc_req <= 1'b1;
              cnt     <= 32'd0;
            end
          end
        end
        WAIT: begin
          // a response in the timeout cycle still completes the op
          if (data_vld) begin
            state <= DONE;
            if (data_has_fault) begin
              exc_vld   <= 1'b1;
              exc_cause <= acc_w_rb ? 4'd7 : 4'd5;
              exc_tval  <= acc_addr;
            end else begin
              wb_vld  <= 1'b1;
              wb_we   <= ~acc_w_rb && (op_rd != 5'd0);
              wb_rd   <= op_rd;
              wb_data <= acc_w_rb ? 32'd0 : ld_val;
            end
          end else if (timed_out) begin
            state     <= DONE;
            exc_vld   <= 1'b1;
            exc_cause <= acc_w_rb ? 4'd7 : 4'd5;
            exc_tval  <= acc_addr;
          end else begin
            cnt <= cnt_next;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - self-checking bench for lsu
// Directed cases then random ops against an address-pattern bus model with variable latency.
module tb_lsu;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ex_vld, ex_we, ex_unsigned;
  logic [1:0]  ex_size;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        lsu_busy, wb_vld, wb_we, exc_vld;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, exc_tval;
  logic [3:0]  exc_cause;
  logic        acc_req, acc_w_rb;
  logic [1:0]  acc_size;
  logic [31:0] acc_addr, acc_wdata;
  logic        data_vld, data_has_fault;
  logic [31:0] data;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  lsu #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn),
    .ex_vld(ex_vld), .ex_we(ex_we), .ex_size(ex_size), .ex_unsigned(ex_unsigned),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .lsu_busy(lsu_busy),
    .wb_vld(wb_vld), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .exc_vld(exc_vld), .exc_cause(exc_cause), .exc_tval(exc_tval),
    .acc_req(acc_req), .acc_w_rb(acc_w_rb), .acc_size(acc_size),
    .acc_addr(acc_addr), .acc_wdata(acc_wdata),
    .data_vld(data_vld), .data(data), .data_has_fault(data_has_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bus_word(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0] & 8'hFC;
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  function automatic bit is_mis(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
  endfunction

  function automatic logic [31:0] ld_exp(input logic [1:0] sz, input bit uns, input logic [31:0] a);
    logic [31:0] v;
    v = bus_word(a) >> (8 * (a % 4));
    if (sz == 2'd0) begin
      v = v % 256;
      if (!uns && v >= 128) v = v + 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      v = v % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] st_exp(input logic [1:0] sz, input logic [31:0] w);
    if (sz == 2'd0) return (w % 256) * 32'h01010101;
    if (sz == 2'd1) return (w % 65536) * 32'h00010001;
    return w;
  endfunction

  task automatic idle_inputs();
    ex_vld = 1'b0; ex_we = 1'b0; ex_size = 2'd0; ex_unsigned = 1'b0;
    ex_addr = 32'd0; ex_wdata = 32'd0; ex_rd = 5'd0;
    data_vld = 1'b0; data = 32'd0; data_has_fault = 1'b0;
  endtask

  task automatic run_op(input string tag, input bit we, input logic [1:0] sz, input bit uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                        input int lat, input bit silent);
    bit mis, afault, tmo;
    int exp_cyc, done_cyc, req_cyc, nreq;
    logic [31:0] r_addr, r_wdata, p_data, p_tval;
    logic [1:0]  r_size;
    logic        r_w, p_wb, p_exc, p_we;
    logic [4:0]  p_rd;
    logic [3:0]  p_cause;
    mis = is_mis(sz, a);
    tmo = !mis && (silent || lat > TMO);
    afault = tmo || (!mis && ((a & 32'hFFFF_FFFC) == 32'h40));
    exp_cyc = mis ? 1 : (tmo ? 1 + TMO : lat + 1);
    done_cyc = 0; req_cyc = 0; nreq = 0;
    r_addr = 0; r_wdata = 0; r_size = 0; r_w = 0;
    p_wb = 0; p_exc = 0; p_we = 0; p_rd = 0; p_data = 0; p_cause = 0; p_tval = 0;

    @(negedge clk);
    ex_vld = 1'b1; ex_we = we; ex_size = sz; ex_unsigned = uns;
    ex_addr = a; ex_wdata = wd; ex_rd = rd;
    #1 chk({tag, "/busy_accept"}, 32'(lsu_busy), 32'd1);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      data_vld = 1'b0; data = 32'd0; data_has_fault = 1'b0;
      if (acc_req) begin
        nreq++;
        req_cyc = cyc;
        r_addr = acc_addr; r_wdata = acc_wdata; r_size = acc_size; r_w = acc_w_rb;
      end
      if (wb_vld || exc_vld) begin
        done_cyc = cyc;
        p_wb = wb_vld; p_exc = exc_vld; p_we = wb_we; p_rd = wb_rd;
        p_data = wb_data; p_cause = exc_cause; p_tval = exc_tval;
        chk({tag, "/busy_done"}, 32'(lsu_busy), 32'd0);
        ex_vld = 1'b0;
        break;
      end
      if (!silent && nreq > 0 && cyc == req_cyc + lat - 1) begin
        data_vld = 1'b1;
        data = bus_word(r_addr);
        data_has_fault = ((r_addr & 32'hFFFF_FFFC) == 32'h40);
      end
    end
    ex_vld = 1'b0;

    chk({tag, "/done_cycle"}, 32'(done_cyc), 32'(exp_cyc));
    chk({tag, "/n_req"}, 32'(nreq), mis ? 32'd0 : 32'd1);
    if (nreq > 0) begin
      chk({tag, "/acc_addr"}, r_addr, a);
      chk({tag, "/acc_size"}, 32'(r_size), 32'(sz));
      chk({tag, "/acc_w_rb"}, 32'(r_w), 32'(we));
      if (we) chk({tag, "/acc_wdata"}, r_wdata, st_exp(sz, wd));
    end
    chk({tag, "/wb_vld"}, 32'(p_wb), 32'(!(mis || afault)));
    chk({tag, "/exc_vld"}, 32'(p_exc), 32'(mis || afault));
    if (mis || afault) begin
      chk({tag, "/cause"}, 32'(p_cause), mis ? (we ? 32'd6 : 32'd4) : (we ? 32'd7 : 32'd5));
      chk({tag, "/tval"}, p_tval, a);
      chk({tag, "/wb_data_idle"}, p_data, 32'd0);
    end else begin
      chk({tag, "/wb_we"}, 32'(p_we), 32'(!we && rd != 0));
      chk({tag, "/wb_data"}, p_data, we ? 32'd0 : ld_exp(sz, uns, a));
      if (!we) chk({tag, "/wb_rd"}, 32'(p_rd), 32'(rd));
      chk({tag, "/cause_idle"}, 32'(p_cause), 32'd0);
    end

    // a stray response while idle must be discarded
    data_vld = 1'b1; data = 32'hDEADBEEF; data_has_fault = 1'b1;
    @(negedge clk);
    data_vld = 1'b0; data = 32'd0; data_has_fault = 1'b0;
    @(negedge clk);
    chk({tag, "/no_extra_pulse"}, 32'({wb_vld, exc_vld, acc_req}), 32'd0);
    chk({tag, "/idle_busy"}, 32'(lsu_busy), 32'd0);
  endtask

  initial begin
    idle_inputs();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset/outputs", 32'({lsu_busy, wb_vld, wb_we, exc_vld, acc_req, acc_w_rb}), 32'd0);
    chk("reset/wb_data", wb_data | acc_addr | acc_wdata | exc_tval, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    run_op("ld_b_7f",    1'b0, 2'd0, 1'b0, 32'h7F, 32'd0,        5'd5, 1, 1'b0);
    run_op("ld_b_83_s",  1'b0, 2'd0, 1'b0, 32'h83, 32'd0,        5'd6, 1, 1'b0);
    run_op("ld_b_83_u",  1'b0, 2'd0, 1'b1, 32'h83, 32'd0,        5'd6, 1, 1'b0);
    run_op("ld_h_86_u",  1'b0, 2'd1, 1'b1, 32'h86, 32'd0,        5'd7, 1, 1'b0);
    run_op("ld_w_84",    1'b0, 2'd2, 1'b0, 32'h84, 32'd0,        5'd8, 1, 1'b0);
    run_op("st_h_22",    1'b1, 2'd1, 1'b0, 32'h22, 32'h1234ABCD, 5'd0, 1, 1'b0);
    run_op("st_w_02",    1'b1, 2'd2, 1'b0, 32'h02, 32'hCAFEF00D, 5'd0, 1, 1'b0);
    run_op("ld_w_40",    1'b0, 2'd2, 1'b0, 32'h40, 32'd0,        5'd9, 1, 1'b0);
    run_op("ld_rd0",     1'b0, 2'd2, 1'b0, 32'h10, 32'd0,        5'd0, 1, 1'b0);
    run_op("ld_timeout", 1'b0, 2'd2, 1'b0, 32'h20, 32'd0,        5'd3, 1, 1'b1);
    run_op("st_timeout", 1'b1, 2'd0, 1'b0, 32'h21, 32'h55,       5'd0, 1, 1'b1);
    run_op("ld_lat_edge",1'b0, 2'd1, 1'b0, 32'hFE, 32'd0,        5'd4, TMO, 1'b0);
    run_op("ld_lat_late",1'b0, 2'd0, 1'b0, 32'hFD, 32'd0,        5'd4, TMO + 1, 1'b0);
    run_op("ld_size3",   1'b0, 2'd3, 1'b0, 32'h00, 32'd0,        5'd1, 1, 1'b0);

    // reset while waiting on the bus drops the op
    @(negedge clk);
    ex_vld = 1'b1; ex_we = 1'b0; ex_size = 2'd2; ex_addr = 32'h30; ex_rd = 5'd2;
    @(negedge clk);
    chk("rst_wait/req", 32'(acc_req), 32'd1);
    rstn = 1'b0; ex_vld = 1'b0;
    @(negedge clk);
    chk("rst_wait/flush", 32'({wb_vld, exc_vld, acc_req, lsu_busy}), 32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_wait/no_pulse", 32'({wb_vld, exc_vld, acc_req, lsu_busy}), 32'd0);
    run_op("after_rst",  1'b0, 2'd0, 1'b0, 32'h31, 32'd0,        5'd2, 2, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra;
      ra = $urandom_range(0, 255);
      run_op($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), ra, $urandom, 5'($urandom_range(0, 31)),
             $urandom_range(1, TMO + 2), ($urandom_range(0, 9) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
